// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA/decrypt stage and the cracking logic around it.
package rc4_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StIncI,
        StWaitSi,
        StReadSi,
        StAddrSj,
        StWaitSj,
        StReadSj,
        StWriteSi,
        StWriteSj,
        StAddrF,
        StWaitF,
        StReadF,
        StWriteDec,
        StDone
    } rc4_state_e;

    localparam logic [7:0]  CHAR_LOW   = 8'h61;
    localparam logic [7:0]  CHAR_HIGH  = 8'h7A;
    localparam logic [7:0]  CHAR_SPACE = 8'h20;
    localparam int unsigned S_DEPTH    = 256;

    // A one-byte message still needs a 1-bit index port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc4_char_check.sv
// Plaintext acceptance test: a byte passes if it is a lowercase letter or a space.
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_valid
);

    always_comb begin
        o_valid = ((i_byte >= CHAR_LOW) && (i_byte <= CHAR_HIGH)) || (i_byte == CHAR_SPACE);
    end

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation over an already-shuffled S array, XOR-decrypting the ROM message
// into the output RAM and tracking whether every plaintext byte is printable lowercase/space.
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LENGTH  = 32,
    parameter bit          EARLY_ABORT = 1'b1
) (
    input  logic                             CLOCK_50,
    input  logic                             reset,
    input  logic                             start,
    input  logic [7:0]                       s_q_data_in,
    output logic [7:0]                       s_address_out,
    output logic [7:0]                       s_data_out,
    output logic                             s_write_enable_out,
    output logic [idx_width(MSG_LENGTH)-1:0] rom_address_out,
    input  logic [7:0]                       rom_q_data_in,
    output logic [idx_width(MSG_LENGTH)-1:0] dec_address_out,
    output logic [7:0]                       dec_data_out,
    output logic                             dec_write_enable_out,
    output logic                             done,
    output logic                             key_valid
);

    localparam int unsigned     KW     = idx_width(MSG_LENGTH);
    localparam logic [KW-1:0]   K_LAST = KW'(MSG_LENGTH - 1);
    localparam logic [KW-1:0]   K_ONE  = KW'(1);

    rc4_state_e    r_state;
    logic [7:0]    r_i;
    logic [7:0]    r_j;
    logic [KW-1:0] r_k;
    logic [7:0]    r_si;
    logic [7:0]    r_sj;
    logic [7:0]    r_f;
    logic          r_key_valid;

    logic [7:0]    w_plain;
    logic          w_plain_ok;

    assign w_plain = r_f ^ rom_q_data_in;

    rc4_char_check u_char_check (
        .i_byte  (w_plain),
        .o_valid (w_plain_ok)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= StIdle;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_si        <= '0;
            r_sj        <= '0;
            r_f         <= '0;
            r_key_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_i         <= '0;
                        r_j         <= '0;
                        r_k         <= '0;
                        r_key_valid <= 1'b1;
                        r_state     <= StIncI;
                    end
                end
                StIncI: begin
                    r_i     <= r_i + 8'd1;
                    r_state <= StWaitSi;
                end
                StWaitSi: r_state <= StReadSi;
                StReadSi: begin
                    r_si    <= s_q_data_in;
                    r_j     <= r_j + s_q_data_in;
                    r_state <= StAddrSj;
                end
                StAddrSj: r_state <= StWaitSj;
                StWaitSj: r_state <= StReadSj;
                StReadSj: begin
                    r_sj    <= s_q_data_in;
                    r_state <= StWriteSi;
                end
                StWriteSi: r_state <= StWriteSj;
                StWriteSj: r_state <= StAddrF;
                StAddrF:   r_state <= StWaitF;
                StWaitF:   r_state <= StReadF;
                StReadF: begin
                    r_f     <= s_q_data_in;
                    r_state <= StWriteDec;
                end
                StWriteDec: begin
                    if (!w_plain_ok) begin
                        r_key_valid <= 1'b0;
                    end
                    if ((r_k == K_LAST) || (EARLY_ABORT && !w_plain_ok)) begin
                        r_state <= StDone;
                    end else begin
                        r_k     <= r_k + K_ONE;
                        r_state <= StIncI;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Memory controls decode straight from the state so each write is a one-cycle pulse.
    always_comb begin
        s_address_out        = '0;
        s_data_out           = '0;
        s_write_enable_out   = 1'b0;
        dec_address_out      = '0;
        dec_data_out         = '0;
        dec_write_enable_out = 1'b0;
        unique case (r_state)
            StIncI:   s_address_out = r_i + 8'd1;
            StAddrSj: s_address_out = r_j;
            StWriteSi: begin
                s_address_out      = r_i;
                s_data_out         = r_sj;
                s_write_enable_out = 1'b1;
            end
            StWriteSj: begin
                s_address_out      = r_j;
                s_data_out         = r_si;
                s_write_enable_out = 1'b1;
            end
            StAddrF:  s_address_out = r_si + r_sj;
            StWriteDec: begin
                dec_address_out      = r_k;
                dec_data_out         = w_plain;
                dec_write_enable_out = 1'b1;
            end
            default: ;
        endcase
    end

    assign rom_address_out = r_k;
    assign done            = (r_state == StDone);
    assign key_valid       = r_key_valid;

endmodule
